// File: rtl/parking_door_ctrl_pkg.sv
// Shared door state encoding and widths for the gate actuator and its status consumers.
package parking_door_ctrl_pkg;

    localparam int unsigned DOOR_STATE_W = 3;

    localparam logic [DOOR_STATE_W-1:0] ST_CLOSED  = 3'd0;
    localparam logic [DOOR_STATE_W-1:0] ST_OPENING = 3'd1;
    localparam logic [DOOR_STATE_W-1:0] ST_OPEN    = 3'd2;
    localparam logic [DOOR_STATE_W-1:0] ST_CLOSING = 3'd3;
    localparam logic [DOOR_STATE_W-1:0] ST_FAULT   = 3'd4;

endpackage

// File: rtl/parking_door_ctrl_hold_timer.sv
// Loadable saturating up-counter used to time how long the door stays open.
module door_hold_timer #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LAST_VAL = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_VAL);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over load, counting stops at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc_c = (cnt_q == LAST);

endmodule

// File: rtl/parking_door_ctrl.sv
// Gate motor controller: opens on request, holds, closes, reverses on obstruction, faults on repeated reversals.
module parking_door_ctrl
    import parking_door_ctrl_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 6,
    parameter int unsigned MAX_REV       = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    door_open_pulse,
    input  logic                    obstruct,
    output logic                    motor_open,
    output logic                    motor_close,
    output logic                    door_closed,
    output logic                    door_is_open,
    output logic                    door_fault,
    output logic [DOOR_STATE_W-1:0] door_state
);

    localparam logic [CNT_W-1:0] TRAVEL_FULL = CNT_W'(TRAVEL_CYCLES);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] REV_LAST    = CNT_W'(MAX_REV - 1);

    logic [DOOR_STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]        pos_q, pos_d;
    logic [CNT_W-1:0]        rev_q, rev_d;
    logic                    motor_open_q, motor_open_d;
    logic                    motor_close_q, motor_close_d;
    logic                    door_closed_q, door_closed_d;
    logic                    door_is_open_q, door_is_open_d;
    logic                    door_fault_q, door_fault_d;

    logic                    hold_clr_c;
    logic                    hold_en_c;
    logic                    hold_tc_c;
    logic [CNT_W-1:0]        hold_cnt;
    logic                    reverse_c;

    // Hold timer restarts on entry to OPEN and on every pulse/obstruction while open.
    door_hold_timer #(
        .CNT_W    (CNT_W),
        .LAST_VAL (HOLD_CYCLES - 1)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (hold_clr_c),
        .en       (hold_en_c),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (hold_cnt),
        .tc_c     (hold_tc_c)
    );

    // A pulse and an obstruction on the same cycle are a single reversal request.
    assign reverse_c = door_open_pulse | obstruct;

    // Next state, position/reversal counters and Moore output decode of the next state.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        rev_d      = rev_q;
        hold_clr_c = 1'b0;
        hold_en_c  = 1'b0;

        case (state_q)
            ST_CLOSED: begin
                if (door_open_pulse) begin
                    state_d = ST_OPENING;
                end
            end
            ST_OPENING: begin
                // >= also covers a reversal taken at full travel, where pos is already saturated.
                if (pos_q >= TRAVEL_LAST) begin
                    state_d    = ST_OPEN;
                    pos_d      = TRAVEL_FULL;
                    hold_clr_c = 1'b1;
                end else begin
                    pos_d = pos_q + CNT_W'(1);
                end
            end
            ST_OPEN: begin
                if (reverse_c) begin
                    hold_clr_c = 1'b1;
                end else if (hold_tc_c) begin
                    state_d = ST_CLOSING;
                end else begin
                    hold_en_c = 1'b1;
                end
            end
            ST_CLOSING: begin
                if (reverse_c) begin
                    rev_d   = rev_q + CNT_W'(1);
                    state_d = (rev_q >= REV_LAST) ? ST_FAULT : ST_OPENING;
                end else if (pos_q <= CNT_W'(1)) begin
                    state_d = ST_CLOSED;
                    pos_d   = '0;
                    rev_d   = '0;
                end else begin
                    pos_d = pos_q - CNT_W'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_CLOSED;
                pos_d   = '0;
                rev_d   = '0;
            end
        endcase

        motor_open_d   = (state_d == ST_OPENING);
        motor_close_d  = (state_d == ST_CLOSING);
        door_closed_d  = (state_d == ST_CLOSED);
        door_is_open_d = (state_d == ST_OPEN);
        door_fault_d   = (state_d == ST_FAULT);
    end

    // State, counters and output registers; reset aborts any motion straight to CLOSED.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_CLOSED;
            pos_q          <= '0;
            rev_q          <= '0;
            motor_open_q   <= 1'b0;
            motor_close_q  <= 1'b0;
            door_closed_q  <= 1'b1;
            door_is_open_q <= 1'b0;
            door_fault_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            rev_q          <= rev_d;
            motor_open_q   <= motor_open_d;
            motor_close_q  <= motor_close_d;
            door_closed_q  <= door_closed_d;
            door_is_open_q <= door_is_open_d;
            door_fault_q   <= door_fault_d;
        end
    end

    assign motor_open   = motor_open_q;
    assign motor_close  = motor_close_q;
    assign door_closed  = door_closed_q;
    assign door_is_open = door_is_open_q;
    assign door_fault   = door_fault_q;
    assign door_state   = state_q;

endmodule
